// File: rtl/loader_pkg.sv
// Shared definitions for the program loader.
//   state_t   : loader FSM states
//   ERR_*     : err_code values reported on load_err
//   CODE_W    : machine-code word width
package loader_pkg;

  typedef enum logic [2:0] {
    S_CNT_LO = 3'd0,
    S_CNT_HI = 3'd1,
    S_W_LO   = 3'd2,
    S_W_HI   = 3'd3,
    S_CK     = 3'd4,
    S_DONE   = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_HDR  = 2'b01;
  localparam logic [1:0] ERR_FMT  = 2'b10;
  localparam logic [1:0] ERR_CK   = 2'b11;

  localparam int CODE_W = 9;

endpackage

// File: rtl/prog_loader.sv
// Byte-stream program loader. Receives a framed program from a host link,
// writes each machine-code word into instruction memory and releases the
// core's reset only once the whole frame has loaded with a valid checksum.
//
// Frame: CNT_LO, CNT_HI, N x (W_LO, W_HI), CK
//   {CNT_HI, CNT_LO} = N-1, W_HI = {7'b0, code[8]}, CK = XOR of all prior bytes.
//
// Ports:
//   clk, reset         clock; asynchronous active-low reset
//   in_valid/in_data   byte stream from host
//   in_ready           loader accepts a byte (high in every non-terminal state)
//   reload             restart a load; only honoured in DONE or ERR
//   wr_en/addr/data    instruction-memory write port (registered, 1-cycle strobe)
//   core_hold          holds the core in reset (low only in DONE)
//   load_done          program loaded and checksum valid
//   load_err/err_code  load aborted and its cause
//   dbg_state          current FSM state, for observation only
//
// Handshake: a byte transfers on a rising edge where in_valid and in_ready are
// both high; with in_valid low nothing in the loader changes.
module prog_loader
  import loader_pkg::*;
#(
  parameter int D = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              reload,
  output logic              wr_en,
  output logic [D-1:0]      wr_addr,
  output logic [CODE_W-1:0] wr_data,
  output logic              core_hold,
  output logic              load_done,
  output logic              load_err,
  output logic [1:0]        err_code,
  output logic [2:0]        dbg_state
);

  state_t              state_q, state_d;
  logic [D-1:0]        cnt_q, cnt_d;      // N-1
  logic [D-1:0]        idx_q, idx_d;      // index of the word being received
  logic [7:0]          lo_q, lo_d;        // pending word LO byte
  logic [7:0]          csum_q, csum_d;    // running XOR checksum
  logic [1:0]          err_q, err_d;
  logic                wr_en_d;
  logic [D-1:0]        wr_addr_d;
  logic [CODE_W-1:0]   wr_data_d;
  logic                accept;
  logic                hdr_bad;
  logic                fmt_bad;

  assign accept  = in_valid && in_ready;
  // Any CNT_HI bit that would land at count bit D or above is illegal.
  assign hdr_bad = |({in_data, 8'h00} >> D);
  assign fmt_bad = |in_data[7:1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_CNT_LO;
      cnt_q    <= '0;
      idx_q    <= '0;
      lo_q     <= '0;
      csum_q   <= '0;
      err_q    <= ERR_NONE;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      lo_q     <= lo_d;
      csum_q   <= csum_d;
      err_q    <= err_d;
      wr_en    <= wr_en_d;
      wr_addr  <= wr_addr_d;
      wr_data  <= wr_data_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    lo_d      = lo_q;
    csum_d    = csum_q;
    err_d     = err_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr;
    wr_data_d = wr_data;

    unique case (state_q)
      S_CNT_LO: if (accept) begin
        cnt_d   = D'(in_data);
        csum_d  = csum_q ^ in_data;
        state_d = S_CNT_HI;
      end
      S_CNT_HI: if (accept) begin
        if (hdr_bad) begin
          err_d   = ERR_HDR;
          state_d = S_ERR;
        end else begin
          // Upper bits of in_data are known zero here, so the shift is exact.
          cnt_d   = cnt_q | (D'(in_data) << 8);
          csum_d  = csum_q ^ in_data;
          state_d = S_W_LO;
        end
      end
      S_W_LO: if (accept) begin
        lo_d    = in_data;
        csum_d  = csum_q ^ in_data;
        state_d = S_W_HI;
      end
      S_W_HI: if (accept) begin
        if (fmt_bad) begin
          err_d   = ERR_FMT;
          state_d = S_ERR;
        end else begin
          wr_en_d   = 1'b1;
          wr_addr_d = idx_q;
          wr_data_d = {in_data[0], lo_q};
          csum_d    = csum_q ^ in_data;
          // Stop at the last word without incrementing, so N = 2^D never wraps.
          if (idx_q == cnt_q) begin
            state_d = S_CK;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_W_LO;
          end
        end
      end
      S_CK: if (accept) begin
        if (in_data == csum_q) begin
          state_d = S_DONE;
        end else begin
          err_d   = ERR_CK;
          state_d = S_ERR;
        end
      end
      S_DONE, S_ERR: if (reload) begin
        state_d = S_CNT_LO;
        cnt_d   = '0;
        idx_d   = '0;
        lo_d    = '0;
        csum_d  = '0;
        err_d   = ERR_NONE;
      end
      default: state_d = S_CNT_LO;
    endcase
  end

  assign in_ready  = (state_q != S_DONE) && (state_q != S_ERR);
  assign core_hold = (state_q != S_DONE);
  assign load_done = (state_q == S_DONE);
  assign load_err  = (state_q == S_ERR);
  assign err_code  = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: a table of per-cycle vectors for the basic
// frames plus hand-written sequences for reset mid-frame and a full 2^D frame.
module tb_prog_loader;

  localparam int D = 10;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic [7:0]   in_data;
  logic         in_ready;
  logic         reload;
  logic         wr_en;
  logic [D-1:0] wr_addr;
  logic [8:0]   wr_data;
  logic         core_hold;
  logic         load_done;
  logic         load_err;
  logic [1:0]   err_code;
  logic [2:0]   dbg_state;

  prog_loader #(.D(D)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .reload    (reload),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .core_hold (core_hold),
    .load_done (load_done),
    .load_err  (load_err),
    .err_code  (err_code),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // packed view: {in_ready, wr_en, wr_addr, wr_data, core_hold, load_done, load_err, err_code}
  localparam int PW = 1 + 1 + D + 9 + 1 + 1 + 1 + 2;
  logic [PW-1:0] got;
  assign got = {in_ready, wr_en, wr_addr, wr_data, core_hold, load_done, load_err, err_code};

  typedef struct {
    string         name;
    logic          v;
    logic [7:0]    d;
    logic          rl;
    logic [PW-1:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(string name, logic v, logic [7:0] d, logic rl,
                              logic rdy, logic we, logic [D-1:0] wa, logic [8:0] wd,
                              logic hold, logic done, logic err, logic [1:0] ec);
    vec_t t;
    t.name = name;
    t.v    = v;
    t.d    = d;
    t.rl   = rl;
    t.exp  = {rdy, we, wa, wd, hold, done, err, ec};
    vecs.push_back(t);
  endfunction

  // busy state (CNT_LO..CK), done, err shorthands
  function automatic void bz(string n, logic v, logic [7:0] d, logic rl,
                             logic we, logic [D-1:0] wa, logic [8:0] wd);
    add(n, v, d, rl, 1'b1, we, wa, wd, 1'b1, 1'b0, 1'b0, 2'b00);
  endfunction
  function automatic void dn(string n, logic v, logic [7:0] d, logic [D-1:0] wa, logic [8:0] wd);
    add(n, v, d, 1'b0, 1'b0, 1'b0, wa, wd, 1'b0, 1'b1, 1'b0, 2'b00);
  endfunction
  function automatic void er(string n, logic v, logic [7:0] d, logic [1:0] ec,
                             logic [D-1:0] wa, logic [8:0] wd);
    add(n, v, d, 1'b0, 1'b0, 1'b0, wa, wd, 1'b1, 1'b0, 1'b1, ec);
  endfunction

  task automatic check(string name, logic [PW-1:0] actual, logic [PW-1:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s got=%h need=%h", name, actual, expected);
    end
  endtask

  task automatic check1(string name, logic [31:0] actual, logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s got=%h need=%h", name, actual, expected);
    end
  endtask

  // ---------------- scoreboard for write strobes ----------------
  logic [D+8:0] exp_q[$];   // {addr, data}
  logic         sb_en = 1'b0;

  always @(negedge clk) begin
    if (sb_en && wr_en) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_extra_write got addr=%h data=%h need=none", wr_addr, wr_data);
      end else begin
        logic [D+8:0] e;
        e = exp_q.pop_front();
        if ({wr_addr, wr_data} !== e) begin
          n_fail++;
          $display("FAIL sb_write got addr=%h data=%h need addr=%h data=%h",
                   wr_addr, wr_data, e[D+8:9], e[8:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(logic v, logic [7:0] d, logic rl);
    @(negedge clk);
    in_valid = v;
    in_data  = d;
    reload   = rl;
    @(posedge clk);
    #1;
  endtask

  task automatic send(logic [7:0] b);
    drive(1'b1, b, 1'b0);
  endtask

  task automatic idle();
    drive(1'b0, 8'($urandom_range(0, 255)), 1'b0);
  endtask

  task automatic send_word(logic [D-1:0] addr, logic [8:0] w, inout logic [7:0] ck, input logic push);
    send(w[7:0]);
    send({7'b0, w[8]});
    ck = ck ^ w[7:0] ^ {7'b0, w[8]};
    if (push) exp_q.push_back({addr, w});
  endtask

  // ---------------- test ----------------
  logic [7:0] ck;
  logic [8:0] words4[4];

  initial begin
    reset    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    reload   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_values", got, {1'b1, 1'b0, 10'd0, 9'd0, 1'b1, 1'b0, 1'b0, 2'b00});
    check1("reset_state", 32'(dbg_state), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // one-word frame 00 00 55 01 54
    bz("a_cnt_lo", 1, 8'h00, 0, 0, 0, 9'h000);
    bz("a_cnt_hi", 1, 8'h00, 0, 0, 0, 9'h000);
    bz("a_w_lo",   1, 8'h55, 0, 0, 0, 9'h000);
    bz("a_w_hi",   1, 8'h01, 0, 1, 0, 9'h155);
    dn("a_ck",     1, 8'h54, 0, 9'h155);
    dn("a_sticky", 1, 8'hAA, 0, 9'h155);
    bz("a_reload", 1, 8'h00, 1, 0, 0, 9'h155);

    // N=3 with in_valid toggled: words 1FF, 000, 0A5, CK 59
    bz("b_cnt_lo", 1, 8'h02, 0, 0, 0, 9'h155);
    bz("b_idle0",  0, 8'h77, 0, 0, 0, 9'h155);
    bz("b_cnt_hi", 1, 8'h00, 0, 0, 0, 9'h155);
    bz("b_idle1",  0, 8'h13, 0, 0, 0, 9'h155);
    bz("b_w0_lo",  1, 8'hFF, 0, 0, 0, 9'h155);
    bz("b_idle2",  0, 8'h01, 0, 0, 0, 9'h155);
    bz("b_w0_hi",  1, 8'h01, 0, 1, 0, 9'h1FF);
    bz("b_idle3",  0, 8'hFE, 0, 0, 0, 9'h1FF);
    bz("b_w1_lo",  1, 8'h00, 0, 0, 0, 9'h1FF);
    bz("b_idle4",  0, 8'h00, 0, 0, 0, 9'h1FF);
    bz("b_w1_hi",  1, 8'h00, 0, 1, 1, 9'h000);
    bz("b_idle5",  0, 8'h59, 0, 0, 1, 9'h000);
    bz("b_w2_lo",  1, 8'hA5, 0, 0, 1, 9'h000);
    bz("b_idle6",  0, 8'h03, 0, 0, 1, 9'h000);
    bz("b_w2_hi",  1, 8'h00, 0, 1, 2, 9'h0A5);
    bz("b_idle7",  0, 8'h59, 0, 0, 2, 9'h0A5);
    dn("b_ck",     1, 8'h59, 2, 9'h0A5);
    bz("b_reload", 1, 8'h00, 1, 0, 2, 9'h0A5);

    // bad header
    bz("c_cnt_lo", 1, 8'h00, 0, 0, 2, 9'h0A5);
    er("c_cnt_hi", 1, 8'h04, 2'b01, 2, 9'h0A5);
    er("c_sticky", 1, 8'h00, 2'b01, 2, 9'h0A5);
    bz("c_reload", 1, 8'h33, 1, 0, 2, 9'h0A5);

    // bad word format
    bz("d_cnt_lo", 1, 8'h00, 0, 0, 2, 9'h0A5);
    bz("d_cnt_hi", 1, 8'h00, 0, 0, 2, 9'h0A5);
    bz("d_w_lo",   1, 8'h12, 0, 0, 2, 9'h0A5);
    er("d_w_hi",   1, 8'h03, 2'b10, 2, 9'h0A5);
    er("d_sticky", 0, 8'h00, 2'b10, 2, 9'h0A5);
    bz("d_reload", 0, 8'h00, 1, 0, 2, 9'h0A5);

    // checksum off by one, reload ignored mid-frame, then good frame
    bz("e_cnt_lo", 1, 8'h00, 1, 0, 2, 9'h0A5);
    bz("e_cnt_hi", 1, 8'h00, 0, 0, 2, 9'h0A5);
    bz("e_w_lo",   1, 8'h55, 1, 0, 2, 9'h0A5);
    bz("e_w_hi",   1, 8'h01, 0, 1, 0, 9'h155);
    er("e_ck_bad", 1, 8'h55, 2'b11, 0, 9'h155);
    bz("e_reload", 1, 8'h00, 1, 0, 0, 9'h155);
    bz("e2_cnt_lo", 1, 8'h00, 0, 0, 0, 9'h155);
    bz("e2_cnt_hi", 1, 8'h00, 0, 0, 0, 9'h155);
    bz("e2_w_lo",   1, 8'h55, 0, 0, 0, 9'h155);
    bz("e2_w_hi",   1, 8'h01, 0, 1, 0, 9'h155);
    dn("e2_ck",     1, 8'h54, 0, 9'h155);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].v, vecs[i].d, vecs[i].rl);
      check(vecs[i].name, got, vecs[i].exp);
    end

    // ---- reset in the middle of a 4-word frame ----
    drive(1'b0, 8'h00, 1'b1);
    reload = 1'b0;
    sb_en  = 1'b1;
    ck = 8'h00;
    send(8'h03); ck ^= 8'h03;
    send(8'h00);
    send_word(0, 9'h123, ck, 1'b1);
    send_word(1, 9'h0BC, ck, 1'b1);
    in_valid = 1'b0;
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("midreset_values", got, {1'b1, 1'b0, 10'd0, 9'd0, 1'b1, 1'b0, 1'b0, 2'b00});
    check1("midreset_state", 32'(dbg_state), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // full 4-word frame after reset
    words4[0] = 9'h1AB; words4[1] = 9'h002; words4[2] = 9'h100; words4[3] = 9'h0FF;
    ck = 8'h00;
    send(8'h03); ck ^= 8'h03;
    send(8'h00);
    for (int i = 0; i < 4; i++) begin
      send_word(D'(i), words4[i], ck, 1'b1);
      if (i == 1) idle();
    end
    check1("f4_before_ck_ready", 32'({in_ready, load_done}), 32'b10);
    send(ck);
    in_valid = 1'b0;
    check1("f4_done", 32'({load_done, core_hold, load_err}), 32'b100);

    // ---- full 2^D-word frame ----
    drive(1'b0, 8'h00, 1'b1);
    reload = 1'b0;
    ck = 8'h00;
    send(8'hFF); ck ^= 8'hFF;
    send(8'h03); ck ^= 8'h03;
    for (int i = 0; i < (1 << D); i++) begin
      send_word(D'(i), 9'(i * 7 + 3), ck, 1'b1);
      if ($urandom_range(0, 15) == 0) idle();
    end
    in_valid = 1'b0;
    @(negedge clk);
    check1("full_in_ck_state", 32'(dbg_state), 32'd4);
    check1("full_not_done", 32'({in_ready, load_done, core_hold}), 32'b101);
    send(ck);
    in_valid = 1'b0;
    check1("full_done", 32'({load_done, core_hold, load_err, err_code}), 32'b10000);
    repeat (3) @(negedge clk);
    check1("sb_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
